d_e_pipe_reg: RTL
=================

// Module: d_e_pipe_reg
// PURPOSE
//  D/E pipeline register of the P7 five-stage MIPS core. Sits directly downstream of
//  the D-stage immediate extender and register-file read. Captures the decoded D-stage
//  bundle (PC, instr, extended imm32, rs/rt operands, exception code, delay-slot flag)
//  each cycle. Inserts a bubble on hazard stall and clears on exception/eret flush.
// PARAMETERS
//  RESET_PC  32'h0000_3000  E_PC value after reset
//  FLUSH_PC  32'h0000_4180  E_PC value loaded on flush (handler entry)
// PORTS
//  clk          in   1   rising-edge clock, sole clock
//  reset        in   1   asynchronous, active-low (0 = reset)
//  stall        in   1   hazard unit: D held, bubble into E
//  flush        in   1   CP0 req / eret: discard D bundle
//  D_PC         in   32  D-stage PC
//  D_instr      in   32  D-stage instruction
//  D_imm32      in   32  extender output
//  D_rs_data    in   32  forwarded rs operand
//  D_rt_data    in   32  forwarded rt operand
//  D_excCode    in   5   exception code so far (0 = none)
//  D_BD         in   1   D instr sits in branch delay slot
//  E_PC E_instr E_imm32 E_rs_data E_rt_data  out 32 each  registered copies
//  E_excCode    out  5   registered exception code
//  E_BD         out  1   registered delay-slot flag
//  E_valid      out  1   1 = E holds a real instruction, 0 = bubble/flushed
//  bubble_cnt   out  32  stall-bubble count (see CONFIGURATION)
//  flush_cnt    out  32  flush count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset==0, async assert, sync-to-clk deassert usage): E_PC=RESET_PC; all
//    other outputs 0; E_valid=0; counters 0. Reset mid-operation kills in-flight bundle.
//  - Latency 1 cycle: D_* sampled at posedge appear on E_* same edge.
//  - Priority per edge: flush > stall > normal load.
//  - flush=1: E_PC=FLUSH_PC; E_instr/imm32/rs/rt=0; E_excCode=0; E_BD=0; E_valid=0.
//  - stall=1 (no flush): bubble. E_instr=0 (sll $0 nop), imm32/rs/rt=0, excCode=0,
//    E_valid=0. E_PC<=D_PC and E_BD<=D_BD so macro-PC/BD stay exact for a later
//    interrupt that lands on the bubble.
//  - Normal: every E_* <= D_*; E_valid=1.
//  - flush and stall together: flush result only; bubble_cnt not incremented.
//  - Back-to-back stalls: one bubble per stalled cycle, E_PC tracks held D_PC.
//  - No handshake beyond stall/flush; E never back-pressures through this block.
// CONFIGURATION
//  Macro DE_PERF_CNT_EN.
//  Defined: bubble_cnt +1 each edge with stall&~flush; flush_cnt +1 each edge with
//    flush; both 32-bit, wrap 32'hFFFF_FFFF -> 0 silently; reset to 0.
//  Undefined: no counter flops; bubble_cnt/flush_cnt tied to 32'h0. Ports always
//    present; all other behaviour identical.
// TESTING
//  1 reset=0 mid-run with D bundle valid -> outputs immediately E_PC=32'h3000, rest 0,
//    E_valid=0; release, next edge loads D bundle.
//  2 D_PC=32'h3004, D_instr=32'h3c011234, D_imm32=32'h12340000, no stall/flush -> next
//    edge E_* equal inputs, E_valid=1.
//  3 stall=1 for 3 edges, D_PC=32'h3010, D_BD=1 -> E_instr=0, E_PC=32'h3010, E_BD=1,
//    E_valid=0 each cycle; bubble_cnt=3 with DE_PERF_CNT_EN, 0 without.
//  4 flush=1 & stall=1 same edge, D_excCode=5'd4 -> E_PC=32'h4180, E_excCode=0,
//    E_valid=0; flush_cnt+1, bubble_cnt unchanged.
//  5 DE_PERF_CNT_EN: force bubble_cnt=32'hFFFF_FFFF, one stall -> bubble_cnt=0.

Source files
------------

// File: rtl/d_e_pipe_reg.sv
// D/E pipeline register of the P7 five-stage MIPS core: captures the decoded D bundle,
// inserts a bubble on stall, clears on flush. Optional perf counters: define DE_PERF_CNT_EN.
module d_e_pipe_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] FLUSH_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_instr,
  input  logic [31:0] D_imm32,
  input  logic [31:0] D_rs_data,
  input  logic [31:0] D_rt_data,
  input  logic [4:0]  D_excCode,
  input  logic        D_BD,
  output logic [31:0] E_PC,
  output logic [31:0] E_instr,
  output logic [31:0] E_imm32,
  output logic [31:0] E_rs_data,
  output logic [31:0] E_rt_data,
  output logic [4:0]  E_excCode,
  output logic        E_BD,
  output logic        E_valid,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      E_PC      <= RESET_PC;
      E_instr   <= '0;
      E_imm32   <= '0;
      E_rs_data <= '0;
      E_rt_data <= '0;
      E_excCode <= '0;
      E_BD      <= 1'b0;
      E_valid   <= 1'b0;
    end else if (flush) begin
      E_PC      <= FLUSH_PC;
      E_instr   <= '0;
      E_imm32   <= '0;
      E_rs_data <= '0;
      E_rt_data <= '0;
      E_excCode <= '0;
      E_BD      <= 1'b0;
      E_valid   <= 1'b0;
    end else if (stall) begin
      // Bubble keeps PC/BD of the held instruction so an interrupt on it reports exactly.
      E_PC      <= D_PC;
      E_instr   <= '0;
      E_imm32   <= '0;
      E_rs_data <= '0;
      E_rt_data <= '0;
      E_excCode <= '0;
      E_BD      <= D_BD;
      E_valid   <= 1'b0;
    end else begin
      E_PC      <= D_PC;
      E_instr   <= D_instr;
      E_imm32   <= D_imm32;
      E_rs_data <= D_rs_data;
      E_rt_data <= D_rt_data;
      E_excCode <= D_excCode;
      E_BD      <= D_BD;
      E_valid   <= 1'b1;
    end
  end

`ifdef DE_PERF_CNT_EN
  logic [31:0] bubble_cnt_r;
  logic [31:0] flush_cnt_r;

  // Counters wrap silently at 32 bits; flush has priority so a flushed stall is not a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt_r <= '0;
      flush_cnt_r  <= '0;
    end else begin
      if (flush)
        flush_cnt_r <= flush_cnt_r + 32'd1;
      else if (stall)
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_r;
  assign flush_cnt  = flush_cnt_r;
`else
  assign bubble_cnt = 32'h0;
  assign flush_cnt  = 32'h0;
`endif

endmodule
